// File: rtl/e203_exu_brslv_flush.sv
// ---------------------------------------------------------------------------
// e203_exu_brslv_flush
//   Branch-resolve / flush stage behind the ALU BJP unit in EXU commit.
//   Detects mispredictions and mret/dret/fence.i commits, computes the
//   redirect PC, and raises a registered flush request to the IFU. The request
//   is held until the IFU acknowledges it. Commit is back-pressured while a
//   flush is outstanding.
//
//   Optional feature macro: E203_BRSLV_PERF_CNT_EN
//     When defined, the block adds saturating 32-bit branch and mispredict
//     counters (perf_bjp_cnt / perf_mis_cnt).
// ---------------------------------------------------------------------------
module e203_exu_brslv_flush #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmt_i_valid,
  output logic            cmt_i_ready,
  input  logic            cmt_i_rv32,
  input  logic            cmt_i_bjp,
  input  logic            cmt_i_mret,
  input  logic            cmt_i_dret,
  input  logic            cmt_i_fencei,
  input  logic            cmt_i_prdt,
  input  logic            cmt_i_rslv,
  input  logic [PC_W-1:0] cmt_i_pc,
  input  logic [PC_W-1:0] cmt_i_tgt,
  input  logic [PC_W-1:0] csr_epc_r,
  input  logic [PC_W-1:0] csr_dpc_r,
  input  logic            excp_flush_req,
  output logic            flush_req,
  input  logic            flush_ack,
  output logic [PC_W-1:0] flush_pc,
  output logic            cmt_mret_ena,
  output logic            cmt_dret_ena
`ifdef E203_BRSLV_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bjp_cnt,
  output logic [31:0]     perf_mis_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_INC2 = PC_W'(2);
  localparam logic [PC_W-1:0] PC_INC4 = PC_W'(4);

  state_t          state_q;
  state_t          state_nxt;
  logic            accept;
  logic            mispredict;
  logic            need_flush;
  logic [PC_W-1:0] redirect_pc;

  // Redirect target selection; PC sums wrap silently modulo 2^PC_W.
  function automatic logic [PC_W-1:0] calc_redirect(
    input logic            mret,
    input logic            dret,
    input logic            fencei,
    input logic            rslv,
    input logic            rv32,
    input logic [PC_W-1:0] pc,
    input logic [PC_W-1:0] tgt,
    input logic [PC_W-1:0] epc,
    input logic [PC_W-1:0] dpc
  );
    logic [PC_W-1:0] res;
    if (mret)        res = epc;
    else if (dret)   res = dpc;
    else if (fencei) res = pc + PC_INC4;
    else if (rslv)   res = tgt;
    else             res = pc + (rv32 ? PC_INC4 : PC_INC2);
    return res;
  endfunction

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign mispredict  = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv);
  assign need_flush  = cmt_i_mret | cmt_i_dret | cmt_i_fencei | mispredict;
  assign accept      = cmt_i_valid & cmt_i_ready;
  assign redirect_pc = calc_redirect(cmt_i_mret, cmt_i_dret, cmt_i_fencei,
                                     cmt_i_rslv, cmt_i_rv32, cmt_i_pc,
                                     cmt_i_tgt, csr_epc_r, csr_dpc_r);

  // The request is the PEND state flop itself, so it is registered and cannot glitch.
  assign flush_req = (state_q == PEND);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and commit back-pressure; ready never looks at cmt_i_valid.
  always_comb begin
    state_nxt   = state_q;
    cmt_i_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmt_i_ready = ~excp_flush_req;
        if (cmt_i_valid & ~excp_flush_req & need_flush) state_nxt = PEND;
      end
      PEND: begin
        if (flush_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the redirect PC on the edge that launches a flush; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pc <= '0;
    end else if ((state_q == IDLE) && accept && need_flush) begin
      flush_pc <= redirect_pc;
    end
  end

  // One-cycle mret/dret commit pulses for the CSR unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_mret_ena <= 1'b0;
      cmt_dret_ena <= 1'b0;
    end else begin
      cmt_mret_ena <= accept & cmt_i_mret;
      cmt_dret_ena <= accept & cmt_i_dret;
    end
  end

`ifdef E203_BRSLV_PERF_CNT_EN
  // Saturating branch / mispredict counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bjp_cnt <= 32'd0;
      perf_mis_cnt <= 32'd0;
    end else begin
      if (accept & cmt_i_bjp)  perf_bjp_cnt <= sat_inc(perf_bjp_cnt);
      if (accept & mispredict) perf_mis_cnt <= sat_inc(perf_mis_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_e203_exu_brslv_flush.sv
// ---------------------------------------------------------------------------
// Testbench for e203_exu_brslv_flush: directed commits, a behavioural model
// checked every cycle on the falling edge, plus literal spot checks.
// ---------------------------------------------------------------------------
module tb_e203_exu_brslv_flush;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmt_i_valid, cmt_i_ready, cmt_i_rv32, cmt_i_bjp;
  logic        cmt_i_mret, cmt_i_dret, cmt_i_fencei, cmt_i_prdt, cmt_i_rslv;
  logic [31:0] cmt_i_pc, cmt_i_tgt, csr_epc_r, csr_dpc_r;
  logic        excp_flush_req, flush_req, flush_ack;
  logic [31:0] flush_pc;
  logic        cmt_mret_ena, cmt_dret_ena;
`ifdef E203_BRSLV_PERF_CNT_EN
  logic [31:0] perf_bjp_cnt, perf_mis_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  e203_exu_brslv_flush #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_rv32(cmt_i_rv32), .cmt_i_bjp(cmt_i_bjp),
    .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret),
    .cmt_i_fencei(cmt_i_fencei), .cmt_i_prdt(cmt_i_prdt),
    .cmt_i_rslv(cmt_i_rslv), .cmt_i_pc(cmt_i_pc), .cmt_i_tgt(cmt_i_tgt),
    .csr_epc_r(csr_epc_r), .csr_dpc_r(csr_dpc_r),
    .excp_flush_req(excp_flush_req), .flush_req(flush_req),
    .flush_ack(flush_ack), .flush_pc(flush_pc),
    .cmt_mret_ena(cmt_mret_ena), .cmt_dret_ena(cmt_dret_ena)
`ifdef E203_BRSLV_PERF_CNT_EN
    , .perf_bjp_cnt(perf_bjp_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A flush is "owed" to the IFU from the cycle after a flushing commit until
  // the cycle after it is acknowledged.
  logic        m_owed;
  logic [31:0] m_pc;
  logic        m_mret, m_dret;
  logic [31:0] m_bjp, m_mis;

  function automatic logic [31:0] model_target();
    if (cmt_i_mret)   return csr_epc_r;
    if (cmt_i_dret)   return csr_dpc_r;
    if (cmt_i_fencei) return cmt_i_pc + 32'd4;
    if (cmt_i_rslv)   return cmt_i_tgt;
    return cmt_i_pc + (cmt_i_rv32 ? 32'd4 : 32'd2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owed = 1'b0; m_pc = 32'd0; m_mret = 1'b0; m_dret = 1'b0;
      m_bjp = 32'd0; m_mis = 32'd0;
    end else begin
      logic took, miss, wants;
      took  = cmt_i_valid && !m_owed && !excp_flush_req;
      miss  = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv);
      wants = cmt_i_mret || cmt_i_dret || cmt_i_fencei || miss;
      m_mret = took && cmt_i_mret;
      m_dret = took && cmt_i_dret;
      if (took && cmt_i_bjp && m_bjp != 32'hFFFF_FFFF) m_bjp = m_bjp + 1;
      if (took && miss && m_mis != 32'hFFFF_FFFF)      m_mis = m_mis + 1;
      if (m_owed) begin
        if (flush_ack) m_owed = 1'b0;
      end else if (took && wants) begin
        m_owed = 1'b1;
        m_pc   = model_target();
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("flush_req", {63'd0, flush_req}, {63'd0, m_owed});
    check("flush_pc", {32'd0, flush_pc}, {32'd0, m_pc});
    check("cmt_i_ready", {63'd0, cmt_i_ready}, {63'd0, (!m_owed && !excp_flush_req)});
    check("cmt_mret_ena", {63'd0, cmt_mret_ena}, {63'd0, m_mret});
    check("cmt_dret_ena", {63'd0, cmt_dret_ena}, {63'd0, m_dret});
`ifdef E203_BRSLV_PERF_CNT_EN
    check("perf_bjp_cnt", {32'd0, perf_bjp_cnt}, {32'd0, m_bjp});
    check("perf_mis_cnt", {32'd0, perf_mis_cnt}, {32'd0, m_mis});
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic commit(input logic bjp, input logic mret, input logic dret,
                        input logic fencei, input logic prdt, input logic rslv,
                        input logic rv32, input logic [31:0] pc, input logic [31:0] tgt);
    cmt_i_bjp = bjp; cmt_i_mret = mret; cmt_i_dret = dret; cmt_i_fencei = fencei;
    cmt_i_prdt = prdt; cmt_i_rslv = rslv; cmt_i_rv32 = rv32;
    cmt_i_pc = pc; cmt_i_tgt = tgt; cmt_i_valid = 1'b1;
    @(posedge clk); #1;
    cmt_i_valid = 1'b0; cmt_i_bjp = 1'b0; cmt_i_mret = 1'b0; cmt_i_dret = 1'b0;
    cmt_i_fencei = 1'b0; cmt_i_prdt = 1'b0; cmt_i_rslv = 1'b0;
  endtask

  task automatic do_ack();
    flush_ack = 1'b1;
    @(posedge clk); #1;
    flush_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmt_i_valid = 1'b0; cmt_i_rv32 = 1'b0; cmt_i_bjp = 1'b0;
    cmt_i_mret = 1'b0; cmt_i_dret = 1'b0; cmt_i_fencei = 1'b0;
    cmt_i_prdt = 1'b0; cmt_i_rslv = 1'b0; cmt_i_pc = '0; cmt_i_tgt = '0;
    csr_epc_r = 32'h4000; csr_dpc_r = 32'h800; excp_flush_req = 1'b0; flush_ack = 1'b0;
    idle(2);
    check("rst_flush_req", {63'd0, flush_req}, 64'd0);
    check("rst_flush_pc", {32'd0, flush_pc}, 64'd0);
    check("rst_ready", {63'd0, cmt_i_ready}, 64'd1);
    rst_n = 1'b1;
    idle(1);

    // 1: correctly predicted taken branch -> no flush
    commit(1, 0, 0, 0, 1, 1, 1, 32'h100, 32'h500);
    check("s1_no_flush", {63'd0, flush_req}, 64'd0);
    idle(1);
    check("s1_ready", {63'd0, cmt_i_ready}, 64'd1);

    // 2: mispredicted not-taken, 32-bit, ack withheld 3 cycles
    commit(1, 0, 0, 0, 1, 0, 1, 32'h200, 32'h900);
    for (int i = 0; i < 3; i++) begin
      check("s2_req", {63'd0, flush_req}, 64'd1);
      check("s2_pc", {32'd0, flush_pc}, 64'h204);
      check("s2_ready", {63'd0, cmt_i_ready}, 64'd0);
      idle(1);
    end
    do_ack();
    check("s2_req_drop", {63'd0, flush_req}, 64'd0);
    check("s2_pc_hold", {32'd0, flush_pc}, 64'h204);
    flush_ack = 1'b1;           // stray ack while idle must be ignored
    idle(1);
    flush_ack = 1'b0;

    // 3: mispredicted taken 16-bit, then fall-through wrap
    commit(1, 0, 0, 0, 0, 1, 0, 32'h1FE, 32'h80);
    check("s3_tgt", {32'd0, flush_pc}, 64'h80);
    do_ack();
    commit(1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'h1234);
    check("s3_wrap", {32'd0, flush_pc}, 64'h0);
    check("s3_wrap_req", {63'd0, flush_req}, 64'd1);
    do_ack();

    // 4: mret, dret, fence.i
    commit(0, 1, 0, 0, 0, 0, 1, 32'h600, 32'h0);
    check("s4_mret_pc", {32'd0, flush_pc}, 64'h4000);
    check("s4_mret_ena", {63'd0, cmt_mret_ena}, 64'd1);
    do_ack();
    check("s4_mret_pulse_end", {63'd0, cmt_mret_ena}, 64'd0);
    commit(0, 0, 1, 0, 0, 0, 1, 32'h604, 32'h0);
    check("s4_dret_pc", {32'd0, flush_pc}, 64'h800);
    check("s4_dret_ena", {63'd0, cmt_dret_ena}, 64'd1);
    do_ack();
    commit(0, 0, 0, 1, 0, 0, 1, 32'h300, 32'h0);
    check("s4_fencei_pc", {32'd0, flush_pc}, 64'h304);
    do_ack();

    // 5a: exception pending in IDLE blocks commit
    excp_flush_req = 1'b1;
    commit(1, 0, 0, 0, 1, 0, 1, 32'h700, 32'h0);
    check("s5_excp_ready", {63'd0, cmt_i_ready}, 64'd0);
    check("s5_excp_noflush", {63'd0, flush_req}, 64'd0);
    excp_flush_req = 1'b0;
    // 5b: exception arriving in PEND does not retract the branch flush
    commit(1, 0, 0, 0, 1, 0, 1, 32'h700, 32'h0);
    excp_flush_req = 1'b1;
    idle(2);
    check("s5_pend_hold", {63'd0, flush_req}, 64'd1);
    check("s5_pend_pc", {32'd0, flush_pc}, 64'h704);
    do_ack();
    check("s5_pend_done", {63'd0, flush_req}, 64'd0);
    excp_flush_req = 1'b0;
    // 5c: async reset mid-PEND drops the request at once
    commit(1, 0, 0, 0, 0, 1, 1, 32'h800, 32'hABC0);
    #2 rst_n = 1'b0;
    #1 check("s5_async_rst", {63'd0, flush_req}, 64'd0);
    check("s5_async_rst_pc", {32'd0, flush_pc}, 64'd0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
    check("s5_after_rst", {63'd0, flush_req}, 64'd0);

`ifdef E203_BRSLV_PERF_CNT_EN
    // 6: five branches, two mispredicted, then saturation
    commit(1, 0, 0, 0, 1, 1, 1, 32'h10, 32'h40);
    commit(1, 0, 0, 0, 0, 0, 1, 32'h14, 32'h40);
    commit(1, 0, 0, 0, 1, 0, 1, 32'h18, 32'h40);
    do_ack();
    commit(1, 0, 0, 0, 0, 0, 0, 32'h1C, 32'h40);
    commit(1, 0, 0, 0, 0, 1, 0, 32'h1E, 32'h40);
    do_ack();
    check("s6_bjp_cnt", {32'd0, perf_bjp_cnt}, 64'd5);
    check("s6_mis_cnt", {32'd0, perf_mis_cnt}, 64'd2);
    force dut.perf_bjp_cnt = 32'hFFFF_FFFF;
    force dut.perf_mis_cnt = 32'hFFFF_FFFF;
    m_bjp = 32'hFFFF_FFFF; m_mis = 32'hFFFF_FFFF;
    #1;
    release dut.perf_bjp_cnt;
    release dut.perf_mis_cnt;
    commit(1, 0, 0, 0, 1, 0, 1, 32'h20, 32'h40);
    check("s6_bjp_sat", {32'd0, perf_bjp_cnt}, 64'hFFFF_FFFF);
    check("s6_mis_sat", {32'd0, perf_mis_cnt}, 64'hFFFF_FFFF);
    do_ack();
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
